// File: rtl/pim_pkg.sv
// Shared types and constants for the PIM command sequencer: opcodes, command payload, NOP, FSM states.
package pim_pkg;

  localparam int unsigned PIM_DATA_W = 32;
  localparam int unsigned PIM_ADDR_W = 10;
  localparam int unsigned PIM_OP_W   = 3;

  localparam logic [PIM_OP_W-1:0] PIM_OP_WRITE = 3'b100;
  localparam logic [PIM_OP_W-1:0] PIM_OP_READ  = 3'b111;

  typedef struct packed {
    logic [PIM_OP_W-1:0]   opcode;
    logic [PIM_ADDR_W-1:0] addr_a;
    logic [PIM_ADDR_W-1:0] addr_b;
    logic [PIM_ADDR_W-1:0] addr_result;
    logic [PIM_DATA_W-1:0] write_data;
  } pim_cmd_t;

  // Idle filler: a read of address 0 never touches SRAM contents and its result is ignored.
  localparam pim_cmd_t PIM_NOP_CMD = '{opcode: PIM_OP_READ, addr_a: '0, addr_b: '0,
                                       addr_result: '0, write_data: '0};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_STALL = 2'd2
  } seq_state_e;

  function automatic logic is_read(input pim_cmd_t cmd);
    return cmd.opcode == PIM_OP_READ;
  endfunction

endpackage

// File: rtl/pim_cmd_fifo.sv
// Synchronous command FIFO; pointers carry one extra wrap bit to separate full from empty.
module pim_cmd_fifo
  import pim_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push_i,
  input  logic     pop_i,
  input  pim_cmd_t wdata_i,
  output pim_cmd_t rdata_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  pim_cmd_t         mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) &&
                   (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q[IDX_W-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: emptiness is defined by the pointers alone.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[IDX_W-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/pim_cmd_sequencer.sv
// Host command front end for the PIM datapath: FIFO-buffered in-order issue plus read response capture.
// Optional PIM_SEQ_PERF_EN adds issued-command and stall-cycle counters.
module pim_cmd_sequencer
  import pim_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_opcode,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_a,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_b,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_result,
  input  logic [DATA_WIDTH-1:0] cmd_write_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] pim_addr_a,
  output logic [ADDR_WIDTH-1:0] pim_addr_b,
  output logic [ADDR_WIDTH-1:0] pim_addr_result,
  output logic [2:0]            pim_opcode,
  output logic [DATA_WIDTH-1:0] pim_write_data,
  input  logic [DATA_WIDTH-1:0] pim_result
`ifdef PIM_SEQ_PERF_EN
  ,
  output logic [31:0]           perf_cmd_count,
  output logic [31:0]           perf_stall_count
`endif
);

  pim_cmd_t              cmd_in, fifo_head;
  pim_cmd_t              issue_q, issue_d;
  logic                  issue_vld_q, issue_vld_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  seq_state_e            state_q, state_d;
  logic                  fifo_full, fifo_empty;
  logic                  push, pop, head_read, issue_read, rsp_free;

  assign cmd_in = '{opcode:      cmd_opcode,
                    addr_a:      PIM_ADDR_W'(cmd_addr_a),
                    addr_b:      PIM_ADDR_W'(cmd_addr_b),
                    addr_result: PIM_ADDR_W'(cmd_addr_result),
                    write_data:  PIM_DATA_W'(cmd_write_data)};

  assign cmd_ready = !fifo_full;
  assign push      = cmd_valid && !fifo_full;

  pim_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (cmd_in),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // A read waits until no read is in flight and the response slot can take its result.
  assign head_read  = !fifo_empty && is_read(fifo_head);
  assign issue_read = issue_vld_q && is_read(issue_q);
  assign rsp_free   = !rsp_valid_q || rsp_ready;
  assign pop        = !fifo_empty && (!head_read || (!issue_read && rsp_free));

  always_comb begin
    state_d     = state_q;
    issue_d     = PIM_NOP_CMD;
    issue_vld_d = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    if (pop) begin
      issue_d     = fifo_head;
      issue_vld_d = 1'b1;
    end
    if (issue_read) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = pim_result;
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
    unique case (state_q)
      ST_IDLE:  if (!fifo_empty) state_d = ST_ISSUE;
      ST_ISSUE: begin
        if (head_read && !pop)       state_d = ST_STALL;
        else if (fifo_empty && !push) state_d = ST_IDLE;
      end
      ST_STALL: if (pop) state_d = ST_ISSUE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Async reset returns the issue stage to NOP at once, so no SRAM write can happen while rst is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_q     <= PIM_NOP_CMD;
      issue_vld_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      issue_q     <= issue_d;
      issue_vld_q <= issue_vld_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign pim_opcode      = issue_q.opcode;
  assign pim_addr_a      = ADDR_WIDTH'(issue_q.addr_a);
  assign pim_addr_b      = ADDR_WIDTH'(issue_q.addr_b);
  assign pim_addr_result = ADDR_WIDTH'(issue_q.addr_result);
  assign pim_write_data  = DATA_WIDTH'(issue_q.write_data);
  assign rsp_valid       = rsp_valid_q;
  assign rsp_data        = rsp_data_q;
  assign busy            = (state_q != ST_IDLE) || issue_vld_q || !fifo_empty;

`ifdef PIM_SEQ_PERF_EN
  logic [31:0] perf_cmd_q, perf_stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cmd_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      if (pop)                  perf_cmd_q   <= perf_cmd_q + 32'd1;
      if (state_q == ST_STALL)  perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_cmd_count   = perf_cmd_q;
  assign perf_stall_count = perf_stall_q;
`endif

endmodule
